// File: rtl/memory_bus_responder.sv
// memory_bus_responder
// Single-clock bus slave for a small CPU: byte RAM, an output port register,
// a synchronized input port, a 16-bit down-counting timer with interrupt,
// and a fixed reset vector.
// Reads are combinational so data is valid in the cycle the address is
// presented; writes take effect on the rising clock edge.

module memory_bus_responder #(
    parameter int          RAM_ADDR_WIDTH = 12,
    parameter logic [15:0] RESET_VECTOR   = 16'h0200
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        READ_write,
    input  logic [15:0] address_in,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic [7:0]  port_in,
    output logic [7:0]  port_out,
    output logic        irq
);

    localparam int RAM_BYTES = 1 << RAM_ADDR_WIDTH;

    // Register addresses
    localparam logic [15:0] ADDR_PORT_OUT  = 16'h8000;
    localparam logic [15:0] ADDR_PORT_IN   = 16'h8001;
    localparam logic [15:0] ADDR_RELOAD_LO = 16'h8002;
    localparam logic [15:0] ADDR_RELOAD_HI = 16'h8003;
    localparam logic [15:0] ADDR_COUNT_LO  = 16'h8004;
    localparam logic [15:0] ADDR_COUNT_HI  = 16'h8005;
    localparam logic [15:0] ADDR_CTRL      = 16'h8006;
    localparam logic [15:0] ADDR_VEC_LO    = 16'hFFFC;
    localparam logic [15:0] ADDR_VEC_HI    = 16'hFFFD;

    // Storage
    logic [7:0]  mem [0:RAM_BYTES-1];
    logic [7:0]  port_out_reg;
    logic [7:0]  sync_1;
    logic [7:0]  sync_2;
    logic [15:0] reload;
    logic [15:0] count;
    logic        run;
    logic        exp_flag;
    logic        irq_en;
    logic        auto_reload;

    // Decode
    logic        ram_hit;
    logic [RAM_ADDR_WIDTH-1:0] ram_index;
    logic        wr_ram;
    logic        wr_port_out;
    logic        wr_reload_lo;
    logic        wr_reload_hi;
    logic        wr_ctrl;
    logic        expire;

    // Timer next-state
    logic [15:0] count_next;
    logic        run_next;
    logic        exp_next;

    // The RAM occupies the bottom of the map; anything with a bit set above
    // the RAM index width falls outside it.
    assign ram_hit   = ((32'(address_in) >> RAM_ADDR_WIDTH) == 32'd0);
    assign ram_index = address_in[RAM_ADDR_WIDTH-1:0];

    assign wr_ram       = READ_write && ram_hit;
    assign wr_port_out  = READ_write && (address_in == ADDR_PORT_OUT);
    assign wr_reload_lo = READ_write && (address_in == ADDR_RELOAD_LO);
    assign wr_reload_hi = READ_write && (address_in == ADDR_RELOAD_HI);
    assign wr_ctrl      = READ_write && (address_in == ADDR_CTRL);

    // Expiry happens on the edge where a running counter sits at zero, so the
    // period is RELOAD+1 edges.
    assign expire = run && (count == 16'd0);

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk_in) begin
        if (wr_ram) begin
            mem[ram_index] <= data_in;
        end
    end

    // Two-flop synchronizer for the asynchronous input pins.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_1 <= 8'h00;
            sync_2 <= 8'h00;
        end else begin
            sync_1 <= port_in;
            sync_2 <= sync_1;
        end
    end

    // Output port and control/reload registers written from the bus.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            port_out_reg <= 8'h00;
            reload       <= 16'h0000;
            irq_en       <= 1'b0;
            auto_reload  <= 1'b0;
        end else begin
            if (wr_port_out) begin
                port_out_reg <= data_in;
            end
            if (wr_reload_lo) begin
                reload[7:0] <= data_in;
            end
            if (wr_reload_hi) begin
                reload[15:8] <= data_in;
            end
            if (wr_ctrl) begin
                irq_en      <= data_in[1];
                auto_reload <= data_in[2];
            end
        end
    end

    // Timer next-state. A RELOAD_HI write restarts the timer and takes
    // priority over expiry handling of COUNT/RUN; EXP still records the
    // expiry, and a set beats a same-edge write-1-to-clear.
    always_comb begin
        count_next = count;
        run_next   = run;
        exp_next   = exp_flag;

        if (wr_ctrl && data_in[0]) begin
            exp_next = 1'b0;
        end
        if (expire) begin
            exp_next = 1'b1;
        end

        if (wr_reload_hi) begin
            count_next = {data_in, reload[7:0]};
            run_next   = 1'b1;
        end else if (run) begin
            if (count != 16'd0) begin
                count_next = count - 16'd1;
            end else if (auto_reload) begin
                count_next = reload;
            end else begin
                count_next = 16'd0;
                run_next   = 1'b0;
            end
        end
    end

    // Timer state registers; reset stops the timer at once.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            count    <= 16'h0000;
            run      <= 1'b0;
            exp_flag <= 1'b0;
        end else begin
            count    <= count_next;
            run      <= run_next;
            exp_flag <= exp_next;
        end
    end

    // Combinational read mux, driven regardless of bus direction.
    always_comb begin
        data_out = 8'hFF;
        if (ram_hit) begin
            data_out = mem[ram_index];
        end else begin
            case (address_in)
                ADDR_PORT_OUT:  data_out = port_out_reg;
                ADDR_PORT_IN:   data_out = sync_2;
                ADDR_RELOAD_LO: data_out = reload[7:0];
                ADDR_RELOAD_HI: data_out = reload[15:8];
                ADDR_COUNT_LO:  data_out = count[7:0];
                ADDR_COUNT_HI:  data_out = count[15:8];
                ADDR_CTRL:      data_out = {4'b0000, run, auto_reload, irq_en, exp_flag};
                ADDR_VEC_LO:    data_out = RESET_VECTOR[7:0];
                ADDR_VEC_HI:    data_out = RESET_VECTOR[15:8];
                default:        data_out = 8'hFF;
            endcase
        end
    end

    assign port_out = port_out_reg;
    // Both terms are flops, so the AND cannot glitch on bus activity.
    assign irq      = exp_flag & irq_en;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Directed bench for memory_bus_responder: a vector table for single-cycle
// register/RAM behaviour, then hand-written sequences for the timer,
// the input synchronizer and asynchronous reset.

module tb_memory_bus_responder;

    logic        clk_in;
    logic        reset;
    logic        READ_write;
    logic [15:0] address_in;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [7:0]  port_in;
    logic [7:0]  port_out;
    logic        irq;

    int n_chk;
    int n_fail;

    memory_bus_responder #(
        .RAM_ADDR_WIDTH(12),
        .RESET_VECTOR  (16'h0200)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .READ_write(READ_write),
        .address_in(address_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .port_in   (port_in),
        .port_out  (port_out),
        .irq       (irq)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  din;
        logic        chk_d;
        logic [7:0]  dout;
        logic [7:0]  pout;
        logic        irq;
    } vec_t;

    vec_t tbl [26];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one bus cycle after the falling edge; the following rising
    // edge commits it. Callers sample #1 after presentation.
    task automatic drive(input logic rw, input logic [15:0] addr, input logic [7:0] din);
        @(negedge clk_in);
        READ_write = rw;
        address_in = addr;
        data_in    = din;
        #1;
    endtask

    task automatic rd(input string name, input logic [15:0] addr, input logic [7:0] exp);
        drive(1'b0, addr, 8'h00);
        chk(name, data_out, exp);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset      = 1'b1;
        READ_write = 1'b0;
        address_in = 16'h0000;
        data_in    = 8'h00;
        port_in    = 8'h00;

        //            rw    addr      din    chk   dout   pout   irq
        tbl[0]  = '{1'b0, 16'hFFFC, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 16'hFFFD, 8'h00, 1'b1, 8'h02, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 16'h9000, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 16'h0123, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 16'h0123, 8'h00, 1'b1, 8'hA5, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 16'h8001, 8'h5A, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[6]  = '{1'b0, 16'h8001, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[7]  = '{1'b1, 16'h8000, 8'hC3, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 16'h8000, 8'h00, 1'b1, 8'hC3, 8'hC3, 1'b0};
        tbl[9]  = '{1'b1, 16'h8002, 8'h7E, 1'b1, 8'h00, 8'hC3, 1'b0};
        tbl[10] = '{1'b0, 16'h8002, 8'h00, 1'b1, 8'h7E, 8'hC3, 1'b0};
        tbl[11] = '{1'b1, 16'h8006, 8'hFF, 1'b1, 8'h00, 8'hC3, 1'b0};
        tbl[12] = '{1'b0, 16'h8006, 8'h00, 1'b1, 8'h06, 8'hC3, 1'b0};
        tbl[13] = '{1'b1, 16'h8006, 8'h00, 1'b1, 8'h06, 8'hC3, 1'b0};
        tbl[14] = '{1'b0, 16'h8006, 8'h00, 1'b1, 8'h00, 8'hC3, 1'b0};
        tbl[15] = '{1'b0, 16'h8004, 8'h00, 1'b1, 8'h00, 8'hC3, 1'b0};
        tbl[16] = '{1'b0, 16'h8005, 8'h00, 1'b1, 8'h00, 8'hC3, 1'b0};
        tbl[17] = '{1'b0, 16'h8003, 8'h00, 1'b1, 8'h00, 8'hC3, 1'b0};
        tbl[18] = '{1'b1, 16'h0FFF, 8'h11, 1'b0, 8'h00, 8'hC3, 1'b0};
        tbl[19] = '{1'b0, 16'h0FFF, 8'h00, 1'b1, 8'h11, 8'hC3, 1'b0};
        tbl[20] = '{1'b1, 16'h1000, 8'h22, 1'b1, 8'hFF, 8'hC3, 1'b0};
        tbl[21] = '{1'b0, 16'h1000, 8'h00, 1'b1, 8'hFF, 8'hC3, 1'b0};
        tbl[22] = '{1'b1, 16'hFFFC, 8'h99, 1'b1, 8'h00, 8'hC3, 1'b0};
        tbl[23] = '{1'b0, 16'hFFFC, 8'h00, 1'b1, 8'h00, 8'hC3, 1'b0};
        tbl[24] = '{1'b0, 16'h8007, 8'h00, 1'b1, 8'hFF, 8'hC3, 1'b0};
        tbl[25] = '{1'b0, 16'h0123, 8'h00, 1'b1, 8'hA5, 8'hC3, 1'b0};

        // Reset state before any clock activity is released
        #2;
        chk("rst_port_out", port_out, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;

        // Table-driven single-cycle checks
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].rw, tbl[i].addr, tbl[i].din);
            if (tbl[i].chk_d) chk($sformatf("vec%0d_dout", i), data_out, tbl[i].dout);
            chk($sformatf("vec%0d_pout", i), port_out, tbl[i].pout);
            chk($sformatf("vec%0d_irq", i), {7'b0, irq}, {7'b0, tbl[i].irq});
        end

        // Input synchronizer latency: 0 -> 3C visible after two edges
        drive(1'b0, 16'h8001, 8'h00);
        port_in = 8'h3C;
        #1;
        chk("sync_edge0", data_out, 8'h00);
        rd("sync_edge1", 16'h8001, 8'h00);
        rd("sync_edge2", 16'h8001, 8'h3C);

        // One-shot timer: RELOAD=3, expiry on the 4th edge after RELOAD_HI
        drive(1'b1, 16'h8002, 8'h03);
        drive(1'b1, 16'h8003, 8'h00);          // E0
        drive(1'b1, 16'h8006, 8'h02);          // E1
        chk("os_ctrl_run", data_out, 8'h08);
        rd("os_cnt_e1", 16'h8004, 8'h02);
        rd("os_cnt_e2", 16'h8004, 8'h01);
        rd("os_ctrl_e3", 16'h8006, 8'h0A);
        chk("os_irq_e3", {7'b0, irq}, 8'h00);
        rd("os_ctrl_e4", 16'h8006, 8'h03);
        chk("os_irq_e4", {7'b0, irq}, 8'h01);
        rd("os_cnt_lo", 16'h8004, 8'h00);
        rd("os_cnt_hi", 16'h8005, 8'h00);
        rd("os_ctrl_idle", 16'h8006, 8'h03);
        drive(1'b1, 16'h8006, 8'h03);          // W1C keeps IRQ_EN
        rd("os_ctrl_clr", 16'h8006, 8'h02);
        chk("os_irq_clr", {7'b0, irq}, 8'h00);

        // Auto-reload timer: period 4, W1C on expiry edge loses to set
        drive(1'b1, 16'h8006, 8'h06);
        drive(1'b1, 16'h8002, 8'h03);
        drive(1'b1, 16'h8003, 8'h00);          // E0
        rd("ar_cnt_e0", 16'h8004, 8'h03);
        rd("ar_cnt_e1", 16'h8004, 8'h02);
        rd("ar_cnt_e2", 16'h8004, 8'h01);
        rd("ar_ctrl_e3", 16'h8006, 8'h0E);
        drive(1'b1, 16'h8006, 8'h07);          // shows state after E4, clears at E5
        chk("ar_ctrl_e4", data_out, 8'h0F);
        chk("ar_irq_e4", {7'b0, irq}, 8'h01);
        rd("ar_ctrl_e5", 16'h8006, 8'h0E);
        chk("ar_irq_e5", {7'b0, irq}, 8'h00);
        rd("ar_cnt_e6", 16'h8004, 8'h01);
        drive(1'b1, 16'h8006, 8'h07);          // W1C presented on expiry edge E8
        chk("ar_ctrl_e7", data_out, 8'h0E);
        rd("ar_set_wins", 16'h8006, 8'h0F);
        chk("ar_irq_e8", {7'b0, irq}, 8'h01);

        // RELOAD_HI write on the expiry edge E12: write wins, EXP still set
        drive(1'b1, 16'h8006, 8'h07);          // clear at E10
        chk("rw_ctrl_e9", data_out, 8'h0F);
        rd("rw_cnt_e10", 16'h8004, 8'h01);
        drive(1'b1, 16'h8003, 8'h00);          // E12 with COUNT==0
        chk("rw_cnt_e11", data_out, 8'h00);
        rd("rw_ctrl_e12", 16'h8006, 8'h0F);
        rd("rw_cnt_e13", 16'h8004, 8'h02);

        // Asynchronous reset mid-count with irq asserted
        drive(1'b1, 16'h8002, 8'h10);
        drive(1'b1, 16'h8003, 8'h00);
        rd("ar_pre_cnt", 16'h8004, 8'h10);
        chk("ar_pre_irq", {7'b0, irq}, 8'h01);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_irq", {7'b0, irq}, 8'h00);
        chk("rst_async_cnt", data_out, 8'h00);
        chk("rst_async_pout", port_out, 8'h00);
        address_in = 16'h8006;
        #1;
        chk("rst_async_ctrl", data_out, 8'h00);
        rd("rst_ram_kept", 16'h0123, 8'hA5);
        rd("rst_sync_clr", 16'h8001, 8'h00);
        @(negedge clk_in);
        reset = 1'b0;
        rd("post_cnt", 16'h8004, 8'h00);
        rd("post_ctrl", 16'h8006, 8'h00);
        rd("post_cnt_idle", 16'h8004, 8'h00);
        rd("post_sync", 16'h8001, 8'h3C);
        rd("post_ram", 16'h0FFF, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_bus_responder.md
MEMORY_BUS_RESPONDER -- requirements
Module: memory_bus_responder

Interface
REQ-001 The block SHALL have parameter RAM_ADDR_WIDTH, default 12, setting internal RAM size to 2^RAM_ADDR_WIDTH bytes mapped from 0x0000.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 16'h0200, the 16-bit value returned at 0xFFFC (low byte) and 0xFFFD (high byte).
REQ-003 Port clk_in, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port READ_write, input, 1 bit: bus direction from the CPU; 0 = read, 1 = write.
REQ-006 Port address_in, input, 16 bits: CPU bus address.
REQ-007 Port data_in, input, 8 bits: write data from the CPU.
REQ-008 Port data_out, output, 8 bits: read data to the CPU.
REQ-009 Port port_in, input, 8 bits: asynchronous external input pins.
REQ-010 Port port_out, output, 8 bits: output port register value.
REQ-011 Port irq, output, 1 bit: timer interrupt request, active-high.

Function
REQ-012 data_out SHALL be combinational from address_in and registered state, so data is valid in the same cycle the address is presented; data_out SHALL be driven regardless of READ_write.
REQ-013 Writes SHALL occur only on a rising clk_in edge with READ_write=1; a write to an unmapped or read-only address SHALL be ignored.
REQ-014 Memory map: RAM 0x0000..2^RAM_ADDR_WIDTH-1 (read/write); 0x8000 PORT_OUT (read/write); 0x8001 PORT_IN (read-only); 0x8002 RELOAD_LO (read/write); 0x8003 RELOAD_HI (read/write); 0x8004 COUNT_LO (read-only); 0x8005 COUNT_HI (read-only); 0x8006 CTRL (read/write); 0xFFFC/0xFFFD reset vector (read-only).
REQ-015 Any other address SHALL read 0xFF.
REQ-016 RAM reads SHALL be asynchronous; RAM contents SHALL NOT be cleared by reset.
REQ-017 PORT_IN SHALL return port_in passed through a two-flop synchronizer, i.e. a pin change is visible on data_out 2 clk_in edges later.
REQ-018 Timer: 16-bit down-counter COUNT, 16-bit RELOAD, flag RUN.
REQ-019 A write to RELOAD_HI SHALL load COUNT with {new RELOAD_HI, RELOAD_LO} and set RUN=1 at that edge, restarting the timer even if it is running.
REQ-020 While RUN=1 and COUNT!=0, COUNT SHALL decrement by 1 per edge.
REQ-021 While RUN=1 and COUNT==0, at the edge: CTRL.EXP SHALL set to 1; if CTRL.AUTO=1, COUNT SHALL reload from RELOAD and RUN stays 1; otherwise RUN SHALL clear and COUNT stays 0.
REQ-022 Expiry period SHALL be RELOAD+1 cycles; RELOAD=0 with AUTO=1 SHALL expire every cycle.
REQ-023 CTRL bit0 = EXP (write 1 to clear, write 0 no effect), bit1 = IRQ_EN, bit2 = AUTO, bit3 = RUN (read-only), bits7:4 read 0.
REQ-024 If an expiry and a write-1-to-clear of EXP occur at the same edge, EXP SHALL end up 1 (set wins).
REQ-025 If a RELOAD_HI write and an expiry occur at the same edge, the write SHALL win: COUNT loads, RUN=1, and EXP is still set.
REQ-026 irq SHALL equal EXP AND IRQ_EN, both taken from registers, and SHALL be glitch-free.
REQ-027 port_out SHALL reflect the PORT_OUT register directly.

Reset
REQ-028 While reset=1, asynchronously: PORT_OUT=0x00, RELOAD=0x0000, COUNT=0x0000, RUN=0, EXP=0, IRQ_EN=0, AUTO=0, synchronizer flops=0; hence port_out=0x00 and irq=0.
REQ-029 Reset asserted mid-count SHALL stop the timer immediately; after release, the timer SHALL stay idle until RELOAD_HI is written.

Verification
REQ-030 Bench SHALL cover these scenarios:
- After reset, read 0xFFFC then 0xFFFD -> data_out 0x00 then 0x02; read 0x9000 -> 0xFF; port_out=0x00, irq=0.
- Write 0xA5 to 0x0123, then read 0x0123 -> 0xA5 in the same cycle; write 0x5A to 0x8001, then read 0x8001 -> unchanged synchronized port_in.
- Write 0x03 to 0x8002, 0x00 to 0x8003, CTRL=0x02 -> EXP set on the 4th edge after the RELOAD_HI write, irq=1 next cycle, RUN=0, COUNT=0.
- Same setup with AUTO=1 -> EXP re-asserts every 4 cycles; write 0x01 to 0x8006 on the expiry edge -> EXP remains 1.
- Change port_in from 0x00 to 0x3C -> read 0x8001 returns 0x00 after 1 edge and 0x3C after 2 edges.
- Assert reset while COUNT=0x0010 and irq=1 -> irq=0, COUNT=0, RUN=0 immediately without a clock; RAM contents preserved.
